// File: rtl/byte_scramble_tx.sv
// Byte-to-serial transmitter with a self-synchronizing 1+x^3+x^5 scrambler.
// Bytes go out MSB first, back-to-back when offered on the last bit of the previous byte.
//
// state | meaning
// IDLE  | no byte in flight; ready for a byte; scrambler is fed constant 0
// SHIFT | serializing the shift register MSB first; ready only on the last bit
module byte_scramble_tx (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_vld,
  output logic       o_data_rdy,
  output logic       o_code,
  output logic       o_byte_start,
  output logic       o_busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  sreg, sreg_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [4:0]  scr;
  logic        accept;
  logic        bit_in;
  logic        code_nxt;
  logic        start_nxt;

  assign o_data_rdy = (state == IDLE) || (cnt == 3'd7);
  assign o_busy     = (state == SHIFT);
  assign accept     = i_data_vld && o_data_rdy;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    bit_in    = 1'b0;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = i_data;
          cnt_nxt   = 3'd0;
        end
      end
      SHIFT: begin
        bit_in    = sreg[7];
        start_nxt = (cnt == 3'd0);
        if (cnt == 3'd7) begin
          if (accept) begin
            sreg_nxt = i_data;
            cnt_nxt  = 3'd0;
          end else begin
            state_nxt = IDLE;
            sreg_nxt  = 8'd0;
            cnt_nxt   = 3'd0;
          end
        end else begin
          sreg_nxt = {sreg[6:0], 1'b0};
          cnt_nxt  = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        sreg_nxt  = 8'd0;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // scr[2] is c(t-3) and scr[0] is c(t-5): newest code bit enters at scr[4]
  assign code_nxt = bit_in ^ scr[2] ^ scr[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      sreg         <= 8'd0;
      cnt          <= 3'd0;
      scr          <= 5'd0;
      o_code       <= 1'b0;
      o_byte_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      sreg         <= sreg_nxt;
      cnt          <= cnt_nxt;
      scr          <= {code_nxt, scr[4:1]};
      o_code       <= code_nxt;
      o_byte_start <= start_nxt;
    end
  end

endmodule

// File: tb/tb_byte_scramble_tx.sv
// Self-checking bench for byte_scramble_tx: bit-queue reference model plus a
// software descrambler on the observed code stream.
module tb_byte_scramble_tx;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       i_data_vld = 1'b0;
  logic       o_data_rdy, o_code, o_byte_start, o_busy;

  byte_scramble_tx dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_data_vld   (i_data_vld),
    .o_data_rdy   (o_data_rdy),
    .o_code       (o_code),
    .o_byte_start (o_byte_start),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Model: plaintext bits still to be sent, with a first-bit-of-byte flag each.
  bit         mq[$];
  bit         sq[$];
  logic [4:0] ch;    // ch[k-1] = expected c(t-k)
  logic [4:0] dh;    // same history built from the observed o_code
  logic       last_code;
  int         cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sq.delete();
    ch = 5'd0;
    dh = 5'd0;
  endtask

  task automatic step(input bit vld, input logic [7:0] d, output bit acc);
    bit   exp_rdy, b, st, c, rb;
    i_data_vld = vld;
    i_data     = d;
    #1;
    exp_rdy = (mq.size() <= 1);
    chk("rdy", {31'd0, o_data_rdy}, {31'd0, exp_rdy});
    chk("busy", {31'd0, o_busy}, {31'd0, mq.size() > 0});
    @(posedge i_clk);
    cyc++;
    b  = 1'b0;
    st = 1'b0;
    if (mq.size() > 0) begin
      b  = mq.pop_front();
      st = sq.pop_front();
    end
    c  = b ^ ch[2] ^ ch[4];
    ch = {ch[3:0], c};
    acc = vld && exp_rdy;
    if (acc) begin
      for (int i = 7; i >= 0; i--) begin
        mq.push_back(d[i]);
        sq.push_back(i == 7);
      end
    end
    #1;
    last_code = o_code;
    chk("code", {31'd0, o_code}, {31'd0, c});
    chk("start", {31'd0, o_byte_start}, {31'd0, st});
    rb = o_code ^ dh[2] ^ dh[4];
    dh = {dh[3:0], o_code};
    chk("descr", {31'd0, rb}, {31'd0, b});
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_code", {31'd0, o_code}, 32'd0);
    chk("rst_start", {31'd0, o_byte_start}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_rdy", {31'd0, o_data_rdy}, 32'd1);
    #10;
    i_rst_n = 1'b1;
  endtask

  initial begin
    bit         acc;
    int         n, k_prev, hold;
    logic [7:0] seq;
    logic [7:0] bytes3 [3];
    cyc = 0;
    model_reset();
    #23;
    i_rst_n = 1'b1;
    chk("por_code", {31'd0, o_code}, 32'd0);
    chk("por_rdy", {31'd0, o_data_rdy}, 32'd1);

    // Idle output stays at zero.
    for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom), acc);

    // Single 0x80 from a clean scrambler: known code sequence.
    do_reset();
    step(1'b1, 8'h80, acc);
    chk("acc80", {31'd0, acc}, 32'd1);
    seq = 8'd0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd0, acc);
      seq = {seq[6:0], last_code};
    end
    chk("seq80", {24'd0, seq}, 32'h96);
    for (int i = 0; i < 6; i++) step(1'b0, 8'd0, acc);

    // Back-to-back bytes with vld held: accepts one byte-time apart.
    bytes3[0] = 8'hA5; bytes3[1] = 8'h3C; bytes3[2] = 8'hFF;
    k_prev = -1;
    for (int j = 0; j < 3; j++) begin
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
        step(1'b1, bytes3[j], acc);
        n++;
      end
      chk("b2b_acc", {31'd0, acc}, 32'd1);
      if (k_prev >= 0) chk("b2b_gap", cyc - k_prev, 32'd8);
      k_prev = cyc;
    end
    for (int i = 0; i < 10; i++) step(1'b0, 8'd0, acc);

    // 0x55 offered mid-byte waits for the last-bit edge.
    step(1'b1, 8'h5A, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, acc);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, 8'h55, acc);
      n++;
    end
    chk("wait55", n, 32'd5);
    for (int i = 0; i < 12; i++) step(1'b0, 8'd0, acc);

    // Reset in the middle of 0xC3 discards the rest.
    step(1'b1, 8'hC3, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, acc);
    #2;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 8'd0, acc);

    // Random byte stream with random gaps.
    for (int j = 0; j < 1000; j++) begin
      logic [7:0] d;
      d = 8'($urandom);
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) step(1'b0, 8'($urandom), acc);
      acc = 1'b0;
      hold = 0;
      while (!acc && hold < 20) begin
        step(1'b1, d, acc);
        hold++;
      end
      if (!acc) chk("rand_acc", 32'd0, 32'd1);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 8'd0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
